if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard-unit hold; decode cannot accept.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump resolved taken, flush fetch.
REQ-006 SHALL have port redirect_pc  input  32  redirect target.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr  output  32  request address, word aligned.
REQ-009 SHALL have port imem_ready  input  1  imem_rdata valid, request complete.
REQ-010 SHALL have port imem_rdata  input  32  fetched word.
REQ-011 SHALL have port instruction_out  output  32  word to IF/ID register.
REQ-012 SHALL have port PC_out  output  32  address of instruction_out.
REQ-013 SHALL have port busywait  output  1  IF/ID hold (no load).
REQ-014 SHALL have port NOP_sel  output  1  IF/ID loads NOP 32'h00000013 instead.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, KILL.
REQ-016 IDLE: one cycle after reset release, imem_req=0, NOP_sel=1; next state FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; stays until imem_ready.
REQ-018 FETCH, imem_ready=1, stall=0: instruction_out=imem_rdata, PC_out=pc, NOP_sel=0, busywait=0; pc<=pc+4; remain FETCH (back-to-back, one instruction/cycle with zero-wait memory).
REQ-019 FETCH, imem_ready=0: NOP_sel=1, busywait=stall (bubble, never duplicate instruction).
REQ-020 FETCH, imem_ready=1, stall=1: word and pc captured in one-entry hold buffer, busywait=1, pc<=pc+4; next HOLD.
REQ-021 HOLD: imem_req=0; outputs drive buffer contents; busywait=stall; on stall=0 buffer issued (NOP_sel=0), next FETCH.
REQ-022 redirect_valid in any state SHALL take priority: NOP_sel=1, busywait=0 that cycle, hold buffer invalidated, pc<=redirect_pc.
REQ-023 redirect in FETCH with imem_ready=0: request outstanding, next KILL; KILL keeps imem_req=1 with original address until imem_ready, discards data, NOP_sel=1, then FETCH at redirect pc.
REQ-024 redirect in FETCH with imem_ready=1 or in HOLD/IDLE: data discarded, next FETCH at redirect_pc.
REQ-025 second redirect during KILL SHALL overwrite the pending target; last one wins.
REQ-026 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-027 pc arithmetic modulo 2^32; 32'hFFFFFFFC+4 wraps to 0; redirect_pc[1:0] forced to 0.

Reset
REQ-028 reset asserted SHALL immediately force: state IDLE, pc=RESET_PC, hold buffer invalid, imem_req=0, instruction_out=32'h00000013, PC_out=0, NOP_sel=1, busywait=0.
REQ-029 reset mid-request SHALL abandon the outstanding access; a late imem_ready SHALL be ignored while not in FETCH/KILL.

Configuration
REQ-030 macro IF_JAL_PREDICT_EN defined: word issued in FETCH/HOLD with opcode 7'b1101111 (JAL) SHALL set next pc to PC_out+sign-extended J-immediate instead of +4 (no bubble); redirect still overrides.
REQ-031 macro undefined: pc always advances by 4; JAL resolved by downstream redirect.

Structure
REQ-032 shared package if_pkg SHALL hold fetch_state_t enum, NOP_INSTR=32'h00000013, OPCODE_JAL, and hold-buffer struct {instr, pc}.
REQ-033 one sub-module if_jal_imm (J-immediate extract/sign-extend), instantiated only under IF_JAL_PREDICT_EN.

Verification
REQ-034 reset released, imem_ready tied 1, rdata=pc -> PC_out 0,4,8,... consecutive cycles from cycle 2, NOP_sel=0.
REQ-035 imem_ready low 3 cycles at addr 0x10 -> 3 NOP_sel=1 cycles, imem_addr stable 0x10, then PC_out=0x10 once.
REQ-036 stall=1 for 2 cycles while 0x20 returns -> busywait=1, no imem_req in HOLD, 0x20 issued exactly once after release, next fetch 0x24.
REQ-037 redirect to 0x100 while 0x40 request pending -> KILL, 0x40 data never issued, next request address 0x100.
REQ-038 redirect and stall same cycle as imem_ready -> redirect wins, NOP_sel=1, buffer empty, fetch 0x100.
REQ-039 IF_JAL_PREDICT_EN, JAL imm=+0x80 at 0x8 -> next imem_addr 0x88 with no bubble; macro off -> 0xC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } hold_buf_t;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_jal_imm.sv
// J-type immediate extraction and sign extension for JAL target prediction.
// Only built when IF_JAL_PREDICT_EN is defined.
`ifdef IF_JAL_PREDICT_EN
module if_jal_imm (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  // imm[20|10:1|11|19:12] sits in instr[31:12]; bit 0 is always zero.
  assign o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                  i_instr[20], i_instr[30:21], 1'b0};

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential fetch with one-entry hold buffer,
// redirect flush and in-flight kill. Optional JAL prediction via IF_JAL_PREDICT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] PC_out,
  output logic        busywait,
  output logic        NOP_sel
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_killAddr;
  hold_buf_t    r_hold;
  logic         r_holdValid;

  fetch_state_t w_nextState;
  logic [31:0]  w_nextPc;
  logic [31:0]  w_seqNextPc;
  logic         w_holdLoad;
  logic         w_holdClear;
  logic         w_killLoad;

`ifdef IF_JAL_PREDICT_EN
  logic [31:0] w_jalImm;
  logic        w_isJal;

  if_jal_imm u_jalImm (
    .i_instr (imem_rdata),
    .o_imm   (w_jalImm)
  );

  assign w_isJal     = (imem_rdata[6:0] == OPCODE_JAL);
  assign w_seqNextPc = w_isJal ? alignPc(r_pc + w_jalImm) : r_pc + 32'd4;
`else
  assign w_seqNextPc = r_pc + 32'd4;
`endif

  // While killing, the abandoned request must keep its original address.
  assign imem_addr = (r_state == KILL) ? r_killAddr : r_pc;

  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_holdLoad      = 1'b0;
    w_holdClear     = 1'b0;
    w_killLoad      = 1'b0;
    imem_req        = 1'b0;
    instruction_out = NOP_INSTR;
    PC_out          = 32'd0;
    NOP_sel         = 1'b1;
    busywait        = 1'b0;

    case (r_state)
      IDLE: w_nextState = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          w_nextState = imem_ready ? FETCH : KILL;
          w_killLoad  = !imem_ready;
        end else if (imem_ready) begin
          instruction_out = imem_rdata;
          PC_out          = r_pc;
          NOP_sel         = 1'b0;
          w_nextPc        = w_seqNextPc;
          if (stall) begin
            busywait    = 1'b1;
            w_holdLoad  = 1'b1;
            w_nextState = HOLD;
          end
        end else begin
          busywait = stall;
        end
      end
      HOLD: begin
        instruction_out = r_hold.instr;
        PC_out          = r_hold.pc;
        NOP_sel         = !r_holdValid;
        busywait        = stall;
        if (!stall) begin
          w_holdClear = 1'b1;
          w_nextState = FETCH;
        end
      end
      KILL: begin
        imem_req = 1'b1;
        busywait = stall;
        if (imem_ready) w_nextState = FETCH;
      end
      default: w_nextState = IDLE;
    endcase

    // A redirect beats everything else: bubble this cycle and retarget.
    if (redirect_valid) begin
      instruction_out = NOP_INSTR;
      PC_out          = 32'd0;
      NOP_sel         = 1'b1;
      busywait        = 1'b0;
      w_nextPc        = alignPc(redirect_pc);
      w_holdClear     = 1'b1;
      w_holdLoad      = 1'b0;
      if (r_state == HOLD || r_state == IDLE) w_nextState = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_killAddr  <= 32'd0;
      r_hold      <= '0;
      r_holdValid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      if (w_killLoad) r_killAddr <= r_pc;
      if (w_holdLoad) begin
        r_hold      <= '{instr: imem_rdata, pc: r_pc};
        r_holdValid <= 1'b1;
      end else if (w_holdClear) begin
        r_holdValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; JAL expectations follow IF_JAL_PREDICT_EN.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] PC_out;
  logic        busywait;
  logic        NOP_sel;

  int vectorCount = 0;
  int missCount   = 0;

  localparam logic [31:0] JAL_WORD = 32'h080000EF;

  if_fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .busywait        (busywait),
    .NOP_sel         (NOP_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the edge; return at the falling edge for sampling.
  task automatic applyStimulus(input logic iStall, input logic iRedir,
                               input logic [31:0] iRedirPc, input logic iReady,
                               input logic [31:0] iRdata);
    @(posedge clk);
    #1;
    stall          = iStall;
    redirect_valid = iRedir;
    redirect_pc    = iRedirPc;
    imem_ready     = iReady;
    imem_rdata     = iRdata;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("rst_instr", instruction_out,   32'h00000013);
    checkOutput("rst_pcout", PC_out,            32'd0);
    checkOutput("rst_nop",   {31'd0, NOP_sel},  32'd1);
    checkOutput("rst_busy",  {31'd0, busywait}, 32'd0);

    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_req", {31'd0, imem_req}, 32'd0);
    checkOutput("idle_nop", {31'd0, NOP_sel},  32'd1);

    // Back-to-back zero-wait fetches from the reset PC.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'(i * 4));
      checkOutput("seq_addr",  imem_addr,        32'(i * 4));
      checkOutput("seq_pcout", PC_out,           32'(i * 4));
      checkOutput("seq_instr", instruction_out,  32'(i * 4));
      checkOutput("seq_nop",   {31'd0, NOP_sel}, 32'd0);
    end

    // Three wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'hDEADBEEF);
      checkOutput("wait_nop",  {31'd0, NOP_sel},  32'd1);
      checkOutput("wait_addr", imem_addr,         32'h10);
      checkOutput("wait_req",  {31'd0, imem_req}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
    checkOutput("wait_pcout", PC_out,           32'h10);
    checkOutput("wait_issue", {31'd0, NOP_sel}, 32'd0);
    for (int a = 32'h14; a < 32'h20; a += 4)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'(a));

    // Stall for two cycles while 0x20 returns.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h20);
    checkOutput("stall_busy1", {31'd0, busywait}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("hold_busy2", {31'd0, busywait}, 32'd1);
    checkOutput("hold_req",   {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("hold_issue_pc",  PC_out,            32'h20);
    checkOutput("hold_issue_ins", instruction_out,   32'h20);
    checkOutput("hold_issue_nop", {31'd0, NOP_sel},  32'd0);
    checkOutput("hold_issue_bw",  {31'd0, busywait}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("post_hold_addr", imem_addr,        32'h24);
    checkOutput("post_hold_nop",  {31'd0, NOP_sel}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h24);
    checkOutput("post_hold_pc", PC_out, 32'h24);
    for (int a = 32'h28; a < 32'h40; a += 4)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'(a));

    // Redirect to 0x100 while the 0x40 request is outstanding.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
    checkOutput("redir_nop",  {31'd0, NOP_sel},  32'd1);
    checkOutput("redir_busy", {31'd0, busywait}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("kill_addr", imem_addr,         32'h40);
    checkOutput("kill_req",  {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h40);
    checkOutput("kill_drop", {31'd0, NOP_sel}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("kill_next_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
    checkOutput("kill_next_pc", PC_out, 32'h100);

    // Redirect, stall and ready in the same cycle.
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 32'h104);
    checkOutput("race_nop",  {31'd0, NOP_sel},  32'd1);
    checkOutput("race_busy", {31'd0, busywait}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("race_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("race_addr", imem_addr,         32'h100);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
    checkOutput("race_pc", PC_out, 32'h100);

    // Second redirect inside KILL wins; misaligned target is forced aligned.
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h202, 1'b0, 32'd0);
    checkOutput("kill2_addr", imem_addr, 32'h104);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h104);
    checkOutput("kill2_drop", {31'd0, NOP_sel}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("kill2_target", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC);
    checkOutput("wrap_pc", PC_out, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // JAL with +0x80 immediate at 0x8.
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b1, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, JAL_WORD);
    checkOutput("jal_pc",    PC_out,          32'h8);
    checkOutput("jal_instr", instruction_out, JAL_WORD);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef IF_JAL_PREDICT_EN
    checkOutput("jal_next", imem_addr, 32'h88);
`else
    checkOutput("jal_next", imem_addr, 32'hC);
`endif

    // Reset in the middle of an outstanding request; a late ready is ignored.
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("mrst_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("mrst_nop",   {31'd0, NOP_sel},  32'd1);
    checkOutput("mrst_pcout", PC_out,            32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF);
    checkOutput("mrst_late_nop", {31'd0, NOP_sel}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("mrst_idle_req", {31'd0, imem_req}, 32'd0);
    checkOutput("mrst_idle_nop", {31'd0, NOP_sel},  32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("mrst_fetch_addr", imem_addr,         32'h0);
    checkOutput("mrst_fetch_req",  {31'd0, imem_req}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
